// File: rtl/leitor_teclado_pkg.sv
// Shared types and constants for the 4x4 matrix keypad reader.
package leitor_teclado_pkg;

  localparam int N_LINHAS  = 4;
  localparam int N_COLUNAS = 4;
  localparam int TECLA_W   = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} estado_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} quadro_e;

endpackage

// File: rtl/sincronizador_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
module sincronizador_2ff #(
  parameter int          W         = 4,
  parameter logic [W-1:0] RESET_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/leitor_teclado_matricial.sv
// 4x4 keypad scanner: one active-low row at a time, per-frame classification
// of closed contacts, and frame-based debounce of press and release.
module leitor_teclado_matricial
  import leitor_teclado_pkg::*;
#(
  parameter int SCAN_DIV   = 4667,
  parameter int DEB_FRAMES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_COLUNAS-1:0] Coluna,
  output logic [N_LINHAS-1:0]  Linha,
  output logic [TECLA_W-1:0]   Tecla,
  output logic                 TeclaValida,
  output logic                 TeclaPressionada
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEB_FRAMES + 1);

  logic [N_COLUNAS-1:0] col_s;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [1:0]           linha_q, linha_d;
  quadro_e              acc_q, acc_d;
  logic [TECLA_W-1:0]   acc_code_q, acc_code_d;
  estado_e              est_q, est_d;
  logic [TECLA_W-1:0]   cand_q, cand_d;
  logic [TECLA_W-1:0]   tecla_q, tecla_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                 valid_q, valid_d;
  logic                 press_q, press_d;

  logic                 amostra, fim_quadro, atinge;
  logic [2:0]           n_lin;
  logic [1:0]           col_idx;
  quadro_e              res;
  logic [TECLA_W-1:0]   res_code;

  sincronizador_2ff #(.W(N_COLUNAS), .RESET_VAL('1)) u_sinc_coluna (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (Coluna),
    .q_o    (col_s)
  );

  always_comb begin
    amostra    = (div_q == DIV_W'(SCAN_DIV - 1));
    fim_quadro = amostra && (linha_q == 2'd3);
    div_d      = amostra ? '0 : div_q + DIV_W'(1);
    linha_d    = amostra ? linha_q + 2'd1 : linha_q;
    Linha          = '1;
    Linha[linha_q] = 1'b0;
  end

  // Merge this row's closed contacts into the running frame classification.
  always_comb begin
    n_lin   = 3'd0;
    col_idx = 2'd0;
    for (int c = 0; c < N_COLUNAS; c++) begin
      if (!col_s[c]) begin
        n_lin   = n_lin + 3'd1;
        col_idx = 2'(c);
      end
    end
    if (n_lin == 3'd0) begin
      res      = acc_q;
      res_code = acc_code_q;
    end else if (n_lin == 3'd1 && acc_q == NONE) begin
      res      = SINGLE;
      res_code = {linha_q, col_idx};
    end else begin
      res      = MULTI;
      res_code = acc_code_q;
    end
    acc_d      = acc_q;
    acc_code_d = acc_code_q;
    if (fim_quadro) begin
      acc_d      = NONE;
      acc_code_d = '0;
    end else if (amostra) begin
      acc_d      = res;
      acc_code_d = res_code;
    end
  end

  always_comb begin
    est_d   = est_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    tecla_d = tecla_q;
    valid_d = 1'b0;
    press_d = press_q;
    cnt_inc = (cnt_q == CNT_W'(DEB_FRAMES)) ? cnt_q : cnt_q + CNT_W'(1);
    atinge  = (cnt_inc == CNT_W'(DEB_FRAMES));
    if (fim_quadro) begin
      unique case (est_q)
        IDLE: if (res == SINGLE) begin
          cand_d = res_code;
          cnt_d  = CNT_W'(1);
          if (DEB_FRAMES == 1) begin
            tecla_d = res_code;
            valid_d = 1'b1;
            press_d = 1'b1;
            est_d   = HELD;
          end else begin
            est_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: if (res == SINGLE && res_code == cand_q) begin
          cnt_d = cnt_inc;
          if (atinge) begin
            tecla_d = cand_q;
            valid_d = 1'b1;
            press_d = 1'b1;
            est_d   = HELD;
          end
        end else if (res == SINGLE) begin
          cand_d = res_code;
          cnt_d  = CNT_W'(1);
        end else begin
          est_d  = IDLE;
        end
        HELD: if (res == NONE) begin
          cnt_d = CNT_W'(1);
          if (DEB_FRAMES == 1) begin
            press_d = 1'b0;
            est_d   = IDLE;
          end else begin
            est_d   = RELEASE;
          end
        end
        RELEASE: if (res == NONE) begin
          cnt_d = cnt_inc;
          if (atinge) begin
            press_d = 1'b0;
            est_d   = IDLE;
          end
        end else begin
          est_d = HELD;
        end
        default: est_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_q      <= '0;
      linha_q    <= '0;
      acc_q      <= NONE;
      acc_code_q <= '0;
      est_q      <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      tecla_q    <= '0;
      valid_q    <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      linha_q    <= linha_d;
      acc_q      <= acc_d;
      acc_code_q <= acc_code_d;
      est_q      <= est_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      tecla_q    <= tecla_d;
      valid_q    <= valid_d;
      press_q    <= press_d;
    end
  end

  assign Tecla            = tecla_q;
  assign TeclaValida      = valid_q;
  assign TeclaPressionada = press_q;

endmodule

// File: tb/tb_leitor_teclado_matricial.sv
// Self-checking bench: a physical keypad model driven per frame, checked
// every cycle against a frame-level behavioural model of press/release.
module tb_leitor_teclado_matricial;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int FRAME = 4 * SD;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] Coluna;
  logic [3:0] Linha;
  logic [3:0] Tecla;
  logic       TeclaValida;
  logic       TeclaPressionada;

  logic [15:0] keys_cur = '0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pulses     = 0;

  // Reference model state, advanced once per complete frame
  bit       m_pressed;
  int       m_tecla;
  int       m_run_key;
  int       m_run;
  int       m_rel;
  bit       exp_valid;

  leitor_teclado_matricial #(.SCAN_DIV(SD), .DEB_FRAMES(DEB)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .Coluna           (Coluna),
    .Linha            (Linha),
    .Tecla            (Tecla),
    .TeclaValida      (TeclaValida),
    .TeclaPressionada (TeclaPressionada)
  );

  always #5 clock = ~clock;

  // Closed key (r,c) pulls column c low while row r is strobed low.
  always_comb begin
    Coluna = 4'hF;
    for (int r = 0; r < 4; r++)
      if (Linha[r] === 1'b0)
        for (int c = 0; c < 4; c++)
          if (keys_cur[4*r+c]) Coluna[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pressed = 0; m_tecla = 0; m_run_key = 0; m_run = 0; m_rel = 0;
    exp_valid = 0; cyc = 0;
  endtask

  task automatic model_step(input logic [15:0] keys);
    int n;
    int code;
    n = $countones(keys);
    code = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) code = i;
    exp_valid = 0;
    if (!m_pressed) begin
      if (n == 1) begin
        m_run = (m_run > 0 && code == m_run_key) ? m_run + 1 : 1;
        m_run_key = code;
        if (m_run >= DEB) begin
          m_pressed = 1; m_tecla = code; exp_valid = 1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (n == 0) begin
      m_rel++;
      if (m_rel >= DEB) begin
        m_pressed = 0; m_rel = 0;
      end
    end else begin
      m_rel = 0;
    end
  endtask

  task automatic cycle_step();
    logic [3:0] el;
    el = 4'hF;
    el[(cyc / SD) % 4] = 1'b0;
    @(negedge clock);
    check("Linha", Linha, el);
    check("TeclaValida", TeclaValida, (cyc == 0) ? exp_valid : 1'b0);
    check("Tecla", Tecla, m_tecla[3:0]);
    check("TeclaPressionada", TeclaPressionada, m_pressed);
    if (TeclaValida === 1'b1) pulses++;
    @(posedge clock); #1;
    cyc = (cyc + 1) % FRAME;
  endtask

  task automatic frame(input logic [15:0] keys);
    keys_cur = keys;
    repeat (FRAME) cycle_step();
    model_step(keys);
    $display("frame keys=%04h exp_valid=%0b exp_tecla=%0d exp_press=%0b",
             keys, exp_valid, m_tecla, m_pressed);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    @(posedge clock); #1;
    repeat (n - 1) begin
      @(negedge clock);
      check("rst_Linha", Linha, 4'b1110);
      check("rst_Tecla", Tecla, 4'd0);
      check("rst_TeclaValida", TeclaValida, 1'b0);
      check("rst_TeclaPressionada", TeclaPressionada, 1'b0);
      @(posedge clock); #1;
    end
    reset_n = 1'b1;
    model_reset();
    $display("reset released after %0d cycles", n);
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] k;
    reset_n = 1'b0;
    model_reset();
    do_reset(3);

    // 1: idle scanning
    repeat (3) frame(16'h0000);
    check("t1_pulses", pulses[15:0], 16'd0);

    // 2: key 9 held then released
    pulses = 0;
    repeat (5) frame(16'(1) << 9);
    repeat (4) frame(16'h0000);
    check("t2_pulses", pulses[15:0], 16'd1);
    check("t2_tecla", Tecla, 4'd9);
    check("t2_press", TeclaPressionada, 1'b0);

    // 3: interrupted burst on key 5
    pulses = 0;
    repeat (2) frame(16'(1) << 5);
    frame(16'h0000);
    repeat (3) frame(16'(1) << 5);
    repeat (4) frame(16'h0000);
    check("t3_pulses", pulses[15:0], 16'd1);
    check("t3_tecla", Tecla, 4'd5);

    // 4: two keys together, then key 0 alone
    pulses = 0;
    repeat (6) frame(16'h8001);
    check("t4_multi_pulses", pulses[15:0], 16'd0);
    repeat (3) frame(16'h0001);
    repeat (2) frame(16'h0000);
    check("t4_pulses", pulses[15:0], 16'd1);
    check("t4_tecla", Tecla, 4'd0);
    repeat (2) frame(16'h0000);

    // 5: bounce during hold
    pulses = 0;
    repeat (4) frame(16'(1) << 3);
    frame(16'h0000);
    repeat (2) frame(16'(1) << 3);
    check("t5_press_hold", TeclaPressionada, 1'b1);
    repeat (4) frame(16'h0000);
    check("t5_pulses", pulses[15:0], 16'd1);
    check("t5_press_rel", TeclaPressionada, 1'b0);

    // 6: reset in the accepting frame of key 7
    pulses = 0;
    repeat (2) frame(16'(1) << 7);
    keys_cur = 16'(1) << 7;
    repeat (FRAME / 2) cycle_step();
    do_reset(2);
    check("t6_pulses_rst", pulses[15:0], 16'd0);
    repeat (4) frame(16'(1) << 7);
    check("t6_pulses", pulses[15:0], 16'd1);
    check("t6_tecla", Tecla, 4'd7);
    repeat (4) frame(16'h0000);

    // Randomised frames biased toward repeats so presses get accepted
    prev = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       k = 16'h0000;
        1:       k = 16'(1) << $urandom_range(0, 15);
        5:       k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: k = prev;
      endcase
      frame(k);
      prev = k;
    end
    repeat (4) frame(16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
